// File: rtl/lif_neuron_core.sv
// -----------------------------------------------------------------------------
// lif_neuron_core
// Leaky integrate-and-fire neuron. Weighted input spikes are summed into a
// saturating accumulator during a timestep. At each timestep boundary the
// membrane potential leaks, absorbs the accumulator and is compared against
// the firing threshold. A spike can be followed by a refractory period that
// lasts a configurable number of timesteps.
//
// Ports
//   CLK             single system clock, rising edge
//   RST_N           asynchronous active-low reset
//   set             config-load strobe (level; acted on at its rising edge)
//   clear           timestep-boundary strobe (level; acted on at its rising edge)
//   cfg_threshold   signed firing threshold
//   cfg_v_reset     signed membrane value after a spike
//   cfg_leak_shift  leak shift amount (0 = no leak)
//   cfg_refractory  refractory length in timesteps
//   in_valid/in_weight/in_ready   weighted input spike handshake
//   spike_out       one-cycle output spike pulse
//   v_mem           registered signed membrane potential
//   configured      high once a configuration has been loaded
// -----------------------------------------------------------------------------
module lif_neuron_core #(
  parameter int WIDTH = 16,
  parameter int REF_W = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    set,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] cfg_threshold,
  input  logic signed [WIDTH-1:0] cfg_v_reset,
  input  logic        [3:0]       cfg_leak_shift,
  input  logic        [REF_W-1:0] cfg_refractory,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_weight,
  output logic                    in_ready,
  output logic                    spike_out,
  output logic signed [WIDTH-1:0] v_mem,
  output logic                    configured
);

  typedef enum logic [1:0] {
    UNCFG     = 2'd0,
    INTEGRATE = 2'd1,
    UPDATE    = 2'd2,
    REFRACT   = 2'd3
  } state_t;

  localparam logic signed [WIDTH-1:0] MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH+1:0] MAX_X  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] MIN_X  = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic        [REF_W-1:0] CNT_ONE = REF_W'(1);

  state_t                  state_reg;
  logic                    set_q_reg;
  logic                    clear_q_reg;
  logic                    spike_reg;
  logic                    configured_reg;
  logic signed [WIDTH-1:0] v_mem_reg;
  logic signed [WIDTH-1:0] acc_reg;
  logic        [REF_W-1:0] refr_cnt_reg;
  logic signed [WIDTH-1:0] cfg_threshold_reg;
  logic signed [WIDTH-1:0] cfg_v_reset_reg;
  logic        [3:0]       cfg_leak_shift_reg;
  logic        [REF_W-1:0] cfg_refractory_reg;

  logic set_rise;
  logic clear_rise;
  logic xfer;

  // Both strobes are levels that may stay high for several cycles; only the
  // first cycle of each high period counts.
  assign set_rise   = set   & ~set_q_reg;
  assign clear_rise = clear & ~clear_q_reg;

  // Accepting during REFRACT lets upstream drain; those weights are dropped.
  assign in_ready = (state_reg == INTEGRATE) || (state_reg == REFRACT);
  assign xfer     = in_valid & in_ready;

  // Accumulator add, one guard bit, clamped to the WIDTH range.
  logic signed [WIDTH:0]   acc_sum;
  logic signed [WIDTH-1:0] acc_sat;

  assign acc_sum = {acc_reg[WIDTH-1], acc_reg} + {in_weight[WIDTH-1], in_weight};
  assign acc_sat = (acc_sum[WIDTH] != acc_sum[WIDTH-1]) ?
                   (acc_sum[WIDTH] ? MIN_W : MAX_W) : acc_sum[WIDTH-1:0];

  // Membrane update: v - (v >>> shift) + acc, evaluated with two guard bits
  // so no intermediate can wrap, then clamped back to WIDTH. A shift of 0
  // would subtract v from itself, so it is defined as "no leak".
  logic signed [WIDTH-1:0] leak_term;
  logic signed [WIDTH+1:0] v_ext;
  logic signed [WIDTH+1:0] leak_ext;
  logic signed [WIDTH+1:0] acc_ext;
  logic signed [WIDTH+1:0] v_wide;
  logic signed [WIDTH-1:0] v_next;
  logic                    fire;

  assign leak_term = (cfg_leak_shift_reg == 4'd0) ? '0 : (v_mem_reg >>> cfg_leak_shift_reg);
  assign v_ext     = {{2{v_mem_reg[WIDTH-1]}}, v_mem_reg};
  assign leak_ext  = {{2{leak_term[WIDTH-1]}}, leak_term};
  assign acc_ext   = {{2{acc_reg[WIDTH-1]}}, acc_reg};
  assign v_wide    = v_ext - leak_ext + acc_ext;
  assign v_next    = (v_wide > MAX_X) ? MAX_W :
                     (v_wide < MIN_X) ? MIN_W : v_wide[WIDTH-1:0];
  assign fire      = (v_next >= cfg_threshold_reg);

  assign spike_out  = spike_reg;
  assign v_mem      = v_mem_reg;
  assign configured = configured_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg          <= UNCFG;
      set_q_reg          <= 1'b0;
      clear_q_reg        <= 1'b0;
      spike_reg          <= 1'b0;
      configured_reg     <= 1'b0;
      v_mem_reg          <= '0;
      acc_reg            <= '0;
      refr_cnt_reg       <= '0;
      cfg_threshold_reg  <= '0;
      cfg_v_reset_reg    <= '0;
      cfg_leak_shift_reg <= '0;
      cfg_refractory_reg <= '0;
    end else begin
      set_q_reg   <= set;
      clear_q_reg <= clear;
      spike_reg   <= 1'b0;

      // Config registers reload on any set rise. Because UPDATE follows the
      // clear rise by one edge, a set rise coinciding with that clear rise
      // has its values in place by the time UPDATE evaluates.
      if (set_rise) begin
        cfg_threshold_reg  <= cfg_threshold;
        cfg_v_reset_reg    <= cfg_v_reset;
        cfg_leak_shift_reg <= cfg_leak_shift;
        cfg_refractory_reg <= cfg_refractory;
      end

      case (state_reg)
        UNCFG: begin
          if (set_rise) begin
            v_mem_reg      <= cfg_v_reset;
            acc_reg        <= '0;
            configured_reg <= 1'b1;
            state_reg      <= INTEGRATE;
          end
        end

        INTEGRATE: begin
          // A transfer in the boundary cycle still belongs to this timestep.
          if (xfer) begin
            acc_reg <= acc_sat;
          end
          if (clear_rise) begin
            state_reg <= UPDATE;
          end
        end

        UPDATE: begin
          acc_reg <= '0;
          if (fire) begin
            v_mem_reg <= cfg_v_reset_reg;
            spike_reg <= 1'b1;
            if (cfg_refractory_reg != '0) begin
              refr_cnt_reg <= cfg_refractory_reg;
              state_reg    <= REFRACT;
            end else begin
              state_reg <= INTEGRATE;
            end
          end else begin
            v_mem_reg <= v_next;
            state_reg <= INTEGRATE;
          end
        end

        REFRACT: begin
          if (clear_rise) begin
            if (refr_cnt_reg <= CNT_ONE) begin
              refr_cnt_reg <= '0;
              acc_reg      <= '0;
              state_reg    <= INTEGRATE;
            end else begin
              refr_cnt_reg <= refr_cnt_reg - CNT_ONE;
            end
          end
        end

        default: begin
          state_reg <= UNCFG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_core.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_core
// Directed bench for lif_neuron_core with hand-computed expected values.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. they show the state produced by the previous edge.
// -----------------------------------------------------------------------------
module tb_lif_neuron_core;

  localparam int WIDTH = 16;
  localparam int REF_W = 4;

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b1;
  logic                    set = 1'b0;
  logic                    clear = 1'b0;
  logic signed [WIDTH-1:0] cfg_threshold = '0;
  logic signed [WIDTH-1:0] cfg_v_reset = '0;
  logic        [3:0]       cfg_leak_shift = '0;
  logic        [REF_W-1:0] cfg_refractory = '0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] in_weight = '0;
  logic                    in_ready;
  logic                    spike_out;
  logic signed [WIDTH-1:0] v_mem;
  logic                    configured;

  int total = 0;
  int bad   = 0;

  lif_neuron_core #(.WIDTH(WIDTH), .REF_W(REF_W)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .set            (set),
    .clear          (clear),
    .cfg_threshold  (cfg_threshold),
    .cfg_v_reset    (cfg_v_reset),
    .cfg_leak_shift (cfg_leak_shift),
    .cfg_refractory (cfg_refractory),
    .in_valid       (in_valid),
    .in_weight      (in_weight),
    .in_ready       (in_ready),
    .spike_out      (spike_out),
    .v_mem          (v_mem),
    .configured     (configured)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_set(input int thr, input int vr, input int leak, input int refr);
    cfg_threshold  = WIDTH'(thr);
    cfg_v_reset    = WIDTH'(vr);
    cfg_leak_shift = 4'(leak);
    cfg_refractory = REF_W'(refr);
    set = 1'b1;
    tick();
    set = 1'b0;
    tick();
    $display("set thr=%0d v_reset=%0d leak=%0d refr=%0d", thr, vr, leak, refr);
  endtask

  task automatic send(input int w);
    in_valid  = 1'b1;
    in_weight = WIDTH'(w);
    tick();
    in_valid  = 1'b0;
    $display("send w=%0d", w);
  endtask

  // Timestep boundary: clear held high two cycles (only the rise counts).
  // Optional transfer and/or set rise in the same cycle as the clear rise.
  task automatic do_timestep(input string tag, input bit with_w, input int w,
                             input bit with_set, input int exp_spike, input int exp_v);
    clear = 1'b1;
    if (with_set) set = 1'b1;
    if (with_w) begin
      in_valid  = 1'b1;
      in_weight = WIDTH'(w);
    end
    tick();                                     // T1: UPDATE
    in_valid = 1'b0;
    check({tag, ".upd_ready"}, int'(in_ready), 0);
    check({tag, ".upd_spike"}, int'(spike_out), 0);
    tick();                                     // T2: result visible
    check({tag, ".spike"}, int'(spike_out), exp_spike);
    check({tag, ".v_mem"}, int'(v_mem), exp_v);
    $display("timestep %s spike=%0d v_mem=%0d", tag, spike_out, v_mem);
    clear = 1'b0;
    set   = 1'b0;
    tick();                                     // T3: pulse gone
    check({tag, ".spike_end"}, int'(spike_out), 0);
    check({tag, ".ready_end"}, int'(in_ready), 1);
  endtask

  // Timestep spent in REFRACT: the weight is accepted but must be discarded.
  task automatic refract_step(input string tag, input int w);
    check({tag, ".ready"}, int'(in_ready), 1);
    send(w);
    clear = 1'b1;
    tick();
    check({tag, ".spike0"}, int'(spike_out), 0);
    tick();
    clear = 1'b0;
    tick();
    check({tag, ".spike1"}, int'(spike_out), 0);
    check({tag, ".v_mem"}, int'(v_mem), 0);
    $display("refract %s v_mem=%0d", tag, v_mem);
  endtask

  initial begin
    // Power-up reset
    #2 RST_N = 1'b0;
    repeat (3) tick();
    check("rst.ready", int'(in_ready), 0);
    check("rst.spike", int'(spike_out), 0);
    check("rst.cfgd", int'(configured), 0);
    check("rst.v_mem", int'(v_mem), 0);
    RST_N = 1'b1;
    tick();
    check("post_rst.ready", int'(in_ready), 0);

    // Basic fire: 30+30+50 = 110 >= 100
    do_set(100, 0, 0, 0);
    check("cfg1.cfgd", int'(configured), 1);
    check("cfg1.v_mem", int'(v_mem), 0);
    check("cfg1.ready", int'(in_ready), 1);
    send(30); send(30); send(50);
    do_timestep("fire", 0, 0, 0, 1, 0);

    // Leak shift 1: 0+40 = 40; then 40-20+40 = 60 (second weight on the clear cycle)
    do_set(100, 0, 1, 0);
    check("cfg2.v_mem", int'(v_mem), 0);
    send(40);
    do_timestep("leak1", 0, 0, 0, 0, 40);
    do_timestep("leak2", 1, 40, 0, 0, 60);

    // Saturation: acc clamps to 32767, 60+32767 clamps, fires at 32767
    do_set(32767, 0, 0, 0);
    send(32767); send(32767);
    do_timestep("sat_pos", 0, 0, 0, 1, 0);
    send(-32768); send(-32768);
    do_timestep("sat_neg1", 0, 0, 0, 0, -32768);
    send(-32768); send(-32768);
    do_timestep("sat_neg2", 0, 0, 0, 0, -32768);

    // Refractory of 2 timesteps: -32768+32767 = -1; -1+200 fires
    do_set(100, 0, 0, 2);
    send(32767); send(32767);
    do_timestep("pre_ref", 0, 0, 0, 0, -1);
    send(200);
    do_timestep("ref_fire", 0, 0, 0, 1, 0);
    refract_step("ref1", 200);
    refract_step("ref2", 200);
    send(200);
    do_timestep("ref_after", 0, 0, 0, 1, 0);

    // Reset while in REFRACT: outputs drop before the next edge
    check("mid_ref.ready", int'(in_ready), 1);
    RST_N = 1'b0;
    #1;
    check("async.ready", int'(in_ready), 0);
    check("async.spike", int'(spike_out), 0);
    check("async.cfgd", int'(configured), 0);
    check("async.v_mem", int'(v_mem), 0);
    tick();
    RST_N = 1'b1;
    tick();

    // Unconfigured: clear pulses and input offers are ignored
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_weight = 16'sd500;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      tick();
      check("uncfg.ready", int'(in_ready), 0);
      check("uncfg.spike", int'(spike_out), 0);
      check("uncfg.cfgd", int'(configured), 0);
      check("uncfg.v_mem", int'(v_mem), 0);
      $display("uncfg clear pulse %0d", i);
    end
    in_valid = 1'b0;

    // Set together with clear: new thr=40, v_reset=7 apply to this UPDATE (5+50=55 >= 40)
    do_set(100, 5, 0, 0);
    check("cfg3.cfgd", int'(configured), 1);
    check("cfg3.v_mem", int'(v_mem), 5);
    send(50);
    cfg_threshold = 16'sd40;
    cfg_v_reset   = 16'sd7;
    do_timestep("simul", 0, 0, 1, 1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron_core.md
LIF_NEURON_CORE -- requirements
Module: lif_neuron_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed width of weight, accumulator and membrane potential.
REQ-002 SHALL have parameter REF_W, default 4: refractory counter width, in timesteps.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port set  input  1  config-load strobe from the timestep generator; level, may stay high several cycles.
REQ-006 SHALL have port clear  input  1  timestep-boundary strobe from the timestep generator; level, may stay high several cycles.
REQ-007 SHALL have port cfg_threshold  input  WIDTH  signed firing threshold.
REQ-008 SHALL have port cfg_v_reset  input  WIDTH  signed post-spike membrane value.
REQ-009 SHALL have port cfg_leak_shift  input  4  leak shift amount; 0 = no leak.
REQ-010 SHALL have port cfg_refractory  input  REF_W  refractory length in timesteps.
REQ-011 SHALL have ports in_valid  input  1 and in_weight  input  WIDTH (signed): weighted input spike.
REQ-012 SHALL have port in_ready  output  1  input accept; transfer when in_valid & in_ready.
REQ-013 SHALL have port spike_out  output  1  one-cycle output spike pulse.
REQ-014 SHALL have port v_mem  output  WIDTH  registered signed membrane potential.
REQ-015 SHALL have port configured  output  1  high once a configuration has been loaded.

Function
REQ-016 SHALL edge-detect set and clear via registered copies: set_rise = set & ~set_q, clear_rise = clear & ~clear_q; actions trigger on rises only.
REQ-017 SHALL implement four states: UNCFG, INTEGRATE, UPDATE, REFRACT.
REQ-018 UNCFG: in_ready=0, clear_rise ignored; set_rise latches all cfg_* inputs, sets v_mem=cfg_v_reset, acc=0, configured=1, next state INTEGRATE.
REQ-019 set_rise in any other state SHALL reload the cfg registers only, leaving v_mem, acc, state and refractory counter unchanged.
REQ-020 INTEGRATE: in_ready=1; each transfer adds in_weight to acc with saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 A transfer in the same cycle as clear_rise SHALL be included in the ending timestep's acc.
REQ-022 clear_rise in INTEGRATE SHALL move to UPDATE on the next edge.
REQ-023 UPDATE lasts one cycle with in_ready=0: v_next = sat(v_mem - (v_mem >>> leak_shift) + acc), computed at WIDTH+2 bits and saturated to WIDTH; leak term is 0 when leak_shift=0.
REQ-024 Firing condition: v_next >= threshold (signed). On fire: v_mem<=v_reset, spike_out=1 for exactly one cycle, then REFRACT with counter=cfg_refractory if it is nonzero, else INTEGRATE.
REQ-025 No fire: v_mem<=v_next, next state INTEGRATE. acc SHALL be cleared on leaving UPDATE in both cases.
REQ-026 Latency: if clear_rise is sampled at cycle T0, UPDATE occupies T1, new v_mem and spike_out are visible in T2, and spike_out is low again in T3.
REQ-027 REFRACT: in_ready=1, and transfers are accepted and discarded; v_mem is held; each clear_rise decrements the counter; the decrement to 0 returns to INTEGRATE with acc=0.
REQ-028 clear_rise during UPDATE SHALL be ignored; the clear period is required to be at least 3 cycles.
REQ-029 Simultaneous set_rise and clear_rise in INTEGRATE: both actions take effect, and the UPDATE uses the newly loaded cfg values.

Reset
REQ-030 RST_N low SHALL immediately force state=UNCFG; spike_out, in_ready, configured, v_mem, acc, counter, cfg registers, set_q and clear_q all 0; this applies in every state, including mid-timestep.
REQ-031 After RST_N deasserts, the block SHALL stay in UNCFG until the next set_rise.

Verification
REQ-032 Fire: threshold=100, v_reset=0, leak=0, refr=0; weights 30, 30, 50; clear -> spike_out high exactly one cycle at T2, v_mem=0.
REQ-033 Leak: threshold=100, leak=1; timestep 1 weight 40 -> v_mem=40; timestep 2 weight 40 -> v_mem=60, no spike.
REQ-034 Saturation: two weights of 32767 -> acc=32767; threshold=32767 -> spike; weights -32768 twice -> v_mem=-32768, no wrap.
REQ-035 Refractory: refr=2, spike, then weight 200 in each of the next two timesteps -> no spike, v_mem=0; 200 in timestep 3 -> spike.
REQ-036 Unconfigured: clear pulses before any set -> in_ready=0, spike_out=0, configured=0, v_mem=0.
REQ-037 Reset mid-REFRACT: RST_N low -> all outputs 0 in the same cycle; after release, set required before any integration.
